// File: rtl/gpu_timing_pkg.sv
// ============================================================================
// Module  : gpu_timing_pkg
// Brief   : 640x480@60 defaults, IRQ bit map and segment-total helper
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gpu_timing_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_CW        = 10;

  localparam int IRQ_VBLANK = 0;
  localparam int IRQ_LINE   = 1;

  function automatic int seg_total(input int visible, input int front,
                                   input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timing_axis.sv
// ============================================================================
// Module  : timing_axis
// Brief   : One raster axis: wrapping counter with registered visible/sync decode
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timing_axis
  import gpu_timing_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK,
  parameter bit POL     = 1'b0,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          wrap,
  output logic          visible,
  output logic          sync
);

  localparam int            c_total      = seg_total(VISIBLE, FRONT, SYNC, BACK);
  localparam logic [CW-1:0] c_last       = CW'(c_total - 1);
  localparam logic [CW-1:0] c_vis_end    = CW'(VISIBLE);
  localparam logic [CW-1:0] c_sync_start = CW'(VISIBLE + FRONT);
  localparam logic [CW-1:0] c_sync_end   = CW'(VISIBLE + FRONT + SYNC - 1);

  logic [CW-1:0] w_count_next;

  assign wrap         = (count == c_last);
  assign w_count_next = wrap ? '0 : count + 1'b1;

  // Decode the next count so visible/sync line up with the count they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= c_last;
      visible <= 1'b0;
      sync    <= ~POL;
    end else if (advance) begin
      count   <= w_count_next;
      visible <= (w_count_next < c_vis_end);
      sync    <= ((w_count_next >= c_sync_start) && (w_count_next <= c_sync_end)) ? POL : ~POL;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module  : vga_timing_gen
// Brief   : Parametrised raster timing generator with line-compare/vblank IRQs
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
  import gpu_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int CW        = DEF_CW
) (
  input  logic          CLK100MHz,
  input  logic          rst,
  input  logic [CW-1:0] line_cmp,
  input  logic [1:0]    irq_en,
  input  logic [1:0]    irq_ack,
  output logic          pix_en,
  output logic [CW-1:0] h_count,
  output logic [CW-1:0] v_count,
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          frame_start,
  output logic [1:0]    irq_status,
  output logic          irq
);

  localparam int            c_dw       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_vblank_line = CW'(V_VISIBLE);

  logic [c_dw-1:0] r_div;
  logic            w_tick;
  logic            w_h_wrap;
  logic            w_v_wrap;
  logic            w_h_vis;
  logic            w_v_vis;
  logic            w_line_start;
  logic [CW-1:0]   w_v_next;
  logic [1:0]      w_events;
  logic [1:0]      w_status_next;

  assign w_tick = (r_div == c_div_last);

  // pix_en is the registered copy of the tick that also advances the counters.
  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst) begin
      r_div  <= '0;
      pix_en <= 1'b0;
    end else begin
      r_div  <= w_tick ? '0 : r_div + 1'b1;
      pix_en <= w_tick;
    end
  end

  timing_axis #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .POL     (HS_POL),
    .CW      (CW)
  ) u_h_axis (
    .clk     (CLK100MHz),
    .rst_n   (rst),
    .advance (w_tick),
    .count   (h_count),
    .wrap    (w_h_wrap),
    .visible (w_h_vis),
    .sync    (hs)
  );

  timing_axis #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .POL     (VS_POL),
    .CW      (CW)
  ) u_v_axis (
    .clk     (CLK100MHz),
    .rst_n   (rst),
    .advance (w_line_start),
    .count   (v_count),
    .wrap    (w_v_wrap),
    .visible (w_v_vis),
    .sync    (vs)
  );

  assign active       = w_h_vis & w_v_vis;
  assign w_line_start = w_tick & w_h_wrap;
  assign w_v_next     = w_v_wrap ? '0 : v_count + 1'b1;

  always_comb begin
    w_events             = 2'b00;
    w_events[IRQ_VBLANK] = w_line_start && (w_v_next == c_vblank_line);
    w_events[IRQ_LINE]   = w_line_start && (w_v_next == line_cmp);
  end

  // An event outranks a simultaneous acknowledge of the same bit.
  assign w_status_next = (irq_status & ~irq_ack) | w_events;

  always_ff @(posedge CLK100MHz or negedge rst) begin
    if (!rst) begin
      frame_start <= 1'b0;
      irq_status  <= 2'b00;
      irq         <= 1'b0;
    end else begin
      frame_start <= w_line_start & w_v_wrap;
      irq_status  <= w_status_next;
      irq         <= |(w_status_next & irq_en);
    end
  end

endmodule

`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised raster timing generator for the gpu. It replaces the fixed 640x480 counters with a block generalised in resolution, porch/sync widths, sync polarity and pixel-clock divide.
- Adds programmable line-compare and vblank interrupt sources, each with status, enable and acknowledge.
- Sits between the CLK100MHz domain and the gpu pixel pipeline and register file. It drives vga_hs/vga_vs directly and feeds irq.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 4 gives 25 MHz from CLK100MHz
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- HS_POL, 0, active level of hs
- VS_POL, 0, active level of vs
- CW, 10, counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)

Ports:
- CLK100MHz  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- line_cmp  in  CW  line number that raises the line interrupt
- irq_en  in  2  enables: bit0 vblank, bit1 line-compare
- irq_ack  in  2  per-source clear pulses, same bit map as irq_en
- pix_en  out  1  one-cycle pixel strobe
- h_count  out  CW  current pixel column
- v_count  out  CW  current line
- active  out  1  high inside the visible area
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- frame_start  out  1  pulse on entry to (0,0)
- irq_status  out  2  latched interrupt sources
- irq  out  1  OR of (irq_status & irq_en)

Behaviour:
- Derived totals: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
- Clock one, asynchronous active-low reset. Reset values:
  - div = 0
  - h_count = H_TOTAL-1, v_count = V_TOTAL-1
  - active = 0, hs = ~HS_POL, vs = ~VS_POL
  - pix_en = 0, frame_start = 0, irq_status = 0, irq = 0
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en is registered and high for exactly one CLK100MHz cycle per CLK_DIV cycles. The first pix_en occurs CLK_DIV cycles after reset release. With CLK_DIV=1, pix_en is constant 1 after the first cycle.
- Counters advance only on the pix_en cycle:
  - h increments; at H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps at V_TOTAL-1.
  - The first pix_en after reset therefore yields (0,0).
- Decode: active, hs and vs are registered alongside the counters and always describe the h_count/v_count values visible in the same cycle, with zero skew.
  - active = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hs asserted (level HS_POL) for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1]
  - vs asserted (level VS_POL) for v in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1]
- frame_start: one-cycle pulse coincident with the outputs first showing (0,0).
- Interrupt events, each a single cycle, registered with the counter update:
  - vblank event when the counters become (0, V_VISIBLE).
  - line event when the counters become (0, line_cmp).
  - line_cmp is sampled continuously. A value >= V_TOTAL never fires.
- Status and irq rules:
  - Status bits set on their event regardless of irq_en.
  - irq_ack[n] clears bit n. If an event and an ack for the same bit land in the same cycle, the set wins.
  - irq is registered: irq = |(irq_status_next & irq_en), so it rises the cycle the status sets.
  - Dropping irq_en masks irq but keeps the status bit.
- Reset mid-frame returns everything to the reset values immediately. There is no partial-frame recovery.

Decomposition:
- Package gpu_timing_pkg holds:
  - 640x480@60 constants (the defaults above)
  - IRQ bit indices: IRQ_VBLANK=0, IRQ_LINE=1
  - a helper function computing the total from the four segment widths
- One sub-module, timing_axis, instantiated twice (horizontal, vertical):
  - parameters: VISIBLE, FRONT, SYNC, BACK, POL, CW
  - inputs: advance enable
  - outputs: count, wrap, visible, sync

Test Plan:
- Defaults, release reset → first pix_en and frame_start 4 cycles later with h=0, v=0, active=1; pix_en period exactly 4 cycles thereafter.
- Defaults, one line → hs=0 for h 656..751 (96 pixels = 384 clocks); active falls at h=640; line period 3200 clocks.
- Defaults, full frame → vs=0 for v 490..491; frame_start period 1,680,000 clocks; vblank status sets at (0,480).
- Small instance (CLK_DIV=1, H 8/2/2/2, V 4/1/1/1, HS_POL=VS_POL=1), line_cmp=2, irq_en=2'b10 → irq rises at (0,2), stays high until irq_ack=2'b10; vblank status=1 but irq unaffected by it.
- Small instance, irq_ack asserted in the same cycle as the (0,2) line event → status bit stays 1; line_cmp=9 (>= V_TOTAL 7) → never fires.
- Assert rst low mid-line at h=300 → outputs return to reset values asynchronously, before the next clock edge; after release the timing restarts at (0,0) after CLK_DIV cycles.
